count_step_sequencer: RTL and testbench
=======================================

Name: count_step_sequencer

Overview:
- Controller for the calculator's N-bit up/down step counter, which counts ±1 or ±2 per enabled clock.
- Shares the counter between two requesters: requester 0 is the keypad front-end and requester 1 is the auto-run sequencer.
- Accepts one burst command per requester via valid/ready, arbitrates round-robin, and drives the counter's enable, direction and step-size controls for the commanded number of cycles.
- Keeps a shadow of the count, flags wrap-around, and reports completion.

Parameters:
- N, 4, counter width in bits; must match the counter instance.
- REP_W, 4, width of the repeat-count field; maximum burst is 2^REP_W-1 steps.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- req_valid  input  2  per-requester command valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; one-hot or zero.
- req_dir0 / req_dir1  input  1 each  direction (1 = down, 0 = up).
- req_inc0 / req_inc1  input  1 each  step size (1 = ±2, 0 = ±1).
- req_reps0 / req_reps1  input  REP_W each  number of steps.
- abort  input  1  terminate the current burst early.
- step_en  output  1  counter enable; the counter steps on each clk edge while high.
- up_down  output  1  direction to counter (same encoding as req_dir).
- inc  output  1  step size to counter.
- shadow_count  output  N  expected counter value after all issued steps.
- busy  output  1  high in GRANT-less states STEP and DONE.
- done  output  1  one-cycle completion pulse.
- done_id  output  1  requester whose burst completed; valid with done.
- wrapped  output  1  valid with done; burst crossed the 0 / 2^N-1 boundary at least once.
- aborted  output  1  valid with done; burst was ended by abort.

Behaviour:
- Reset state, applied at the clk edge where reset=1:
  - FSM to IDLE; shadow_count=0.
  - step_en, up_down, inc, done, done_id, wrapped, aborted, busy all 0.
  - last_grant=1, so requester 0 wins the first contention.
  - Reset overrides everything, including mid-burst; no done pulse is emitted for a killed burst.
- FSM states: IDLE, STEP, DONE.
- IDLE:
  - req_ready is combinational. If exactly one req_valid bit is set, that requester gets ready. If both are set, the requester != last_grant gets ready. If none are set, req_ready=0.
  - Handshake completes at the edge where valid&ready. At that edge: latch dir, inc, reps and id; set last_grant=id; clear the wrap and abort accumulators.
  - If reps=0, go to DONE; otherwise go to STEP with remaining=reps.
- STEP:
  - step_en=1, with up_down and inc driven from the latched command, registered so they are stable for the whole state.
  - Each cycle: remaining decrements, and shadow_count updates modulo 2^N by ±1 or ±2.
  - Wrap condition: up and shadow+step ≥ 2^N, or down and shadow < step. When it holds, set the wrap accumulator.
  - Leave to DONE after the step where remaining reaches 0. Burst of R steps gives step_en high for exactly R consecutive cycles.
  - abort=1 in STEP: no step issued that cycle (step_en=0 combinationally gated), go to DONE, set aborted.
  - abort is ignored in IDLE and DONE.
- DONE: done=1 for one cycle, with done_id, wrapped and aborted; req_ready=0; next state IDLE.
- Latency: handshake at edge T gives step_en high during cycles T+1..T+R and done during T+R+1. For reps=0, done is during T+1.
- req_ready=0 in STEP and DONE. Requesters hold valid and fields stable until ready.
- Back-to-back bursts: a new grant is possible in the first IDLE cycle after DONE. The minimum gap between bursts is 1 IDLE cycle.
- shadow_count never changes outside STEP, except at reset.

Test Plan:
- Reset, then req0 up/inc=0/reps=3 -> ready0 at T; step_en high for 3 cycles with up_down=0, inc=0; shadow 0→1→2→3; done at T+4 with done_id=0, wrapped=0.
- Shadow=3 (N=4), req1 down/inc=1/reps=2 -> shadow 3→1→15; done_id=1, wrapped=1.
- Both valid in IDLE after reset -> req0 granted first; after its DONE with both still valid, req1 is granted next.
- req0 reps=0 -> ready pulse, no step_en, done on the next cycle, shadow unchanged.
- req0 up/inc=1/reps=10 from shadow 0, abort asserted on the 4th STEP cycle -> 3 steps issued (shadow=6); done with aborted=1.
- reset asserted during STEP with reps=8 -> next cycle IDLE, step_en=0, shadow_count=0, no done pulse.

Source files
------------

// File: rtl/count_step_sequencer.sv
// Burst controller for the shared up/down step counter: arbitrates two requesters
// round-robin, drives step enable/direction/size and tracks the expected count.
module count_step_sequencer #(
    parameter int unsigned N     = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic             req_dir0,
    input  logic             req_inc0,
    input  logic [REP_W-1:0] req_reps0,
    input  logic             req_dir1,
    input  logic             req_inc1,
    input  logic [REP_W-1:0] req_reps1,
    input  logic             abort,
    output logic             step_en,
    output logic             up_down,
    output logic             inc,
    output logic [N-1:0]     shadow_count,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             wrapped,
    output logic             aborted
);
    localparam int unsigned NW = N + 1;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t           state, state_next;
    logic             last_grant;
    logic             cmd_id, cmd_dir, cmd_inc;
    logic             wrap_acc, abort_acc;
    logic [REP_W-1:0] remaining;
    logic [N-1:0]     shadow;

    logic             grant_id;
    logic             accept;
    logic             sel_dir, sel_inc;
    logic [REP_W-1:0] sel_reps;
    logic [NW-1:0]    step_w;
    logic [NW-1:0]    up_sum;
    logic             wrap_now;
    logic [N-1:0]     shadow_next;

    // Round-robin arbitration; only offered while idle.
    always_comb begin
        req_ready = 2'b00;
        grant_id  = 1'b0;
        if (state == IDLE) begin
            unique case (req_valid)
                2'b01:   begin req_ready = 2'b01; grant_id = 1'b0; end
                2'b10:   begin req_ready = 2'b10; grant_id = 1'b1; end
                2'b11:   begin
                    grant_id  = ~last_grant;
                    req_ready = last_grant ? 2'b01 : 2'b10;
                end
                default: begin req_ready = 2'b00; grant_id = 1'b0; end
            endcase
        end
    end

    assign accept   = |req_ready;
    assign sel_dir  = grant_id ? req_dir1  : req_dir0;
    assign sel_inc  = grant_id ? req_inc1  : req_inc0;
    assign sel_reps = grant_id ? req_reps1 : req_reps0;

    // Step arithmetic, one bit wider so the carry/borrow exposes a wrap.
    assign step_w      = cmd_inc ? NW'(2) : NW'(1);
    assign up_sum      = {1'b0, shadow} + step_w;
    assign wrap_now    = cmd_dir ? ({1'b0, shadow} < step_w) : up_sum[N];
    assign shadow_next = cmd_dir ? (shadow - step_w[N-1:0]) : up_sum[N-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = (sel_reps == '0) ? DONE : STEP;
            STEP: if (abort || remaining == REP_W'(1)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        step_en = (state == STEP) && !abort;
        up_down = (state == STEP) && cmd_dir;
        inc     = (state == STEP) && cmd_inc;
        busy    = (state != IDLE);
        done    = (state == DONE);
        done_id = done && cmd_id;
        wrapped = done && wrap_acc;
        aborted = done && abort_acc;
    end

    // Command latch, shadow count and per-burst accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_dir    <= 1'b0;
            cmd_inc    <= 1'b0;
            remaining  <= '0;
            shadow     <= '0;
            wrap_acc   <= 1'b0;
            abort_acc  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    cmd_id     <= grant_id;
                    cmd_dir    <= sel_dir;
                    cmd_inc    <= sel_inc;
                    remaining  <= sel_reps;
                    last_grant <= grant_id;
                    wrap_acc   <= 1'b0;
                    abort_acc  <= 1'b0;
                end
                STEP: begin
                    if (abort) begin
                        abort_acc <= 1'b1;
                    end else begin
                        remaining <= remaining - REP_W'(1);
                        shadow    <= shadow_next;
                        if (wrap_now) wrap_acc <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign shadow_count = shadow;
endmodule

// File: tb/tb_count_step_sequencer.sv
// Bench for count_step_sequencer: fixed burst table, multi-cycle corner sequences
// and random bursts scored against an arithmetic model of the count.
module tb_count_step_sequencer;
    localparam int unsigned N     = 4;
    localparam int unsigned REP_W = 4;
    localparam int          MODV  = 1 << N;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic             req_dir0, req_inc0, req_dir1, req_inc1;
    logic [REP_W-1:0] req_reps0, req_reps1;
    logic             abort;
    logic             step_en, up_down, inc;
    logic [N-1:0]     shadow_count;
    logic             busy, done, done_id, wrapped, aborted;

    count_step_sequencer #(.N(N), .REP_W(REP_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dir0(req_dir0), .req_inc0(req_inc0), .req_reps0(req_reps0),
        .req_dir1(req_dir1), .req_inc1(req_inc1), .req_reps1(req_reps1),
        .abort(abort),
        .step_en(step_en), .up_down(up_down), .inc(inc),
        .shadow_count(shadow_count), .busy(busy), .done(done),
        .done_id(done_id), .wrapped(wrapped), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id, dir, inc_v, reps, ab, exp_sh, exp_wr;
    } vec_t;

    vec_t tbl[8];
    int   n_pass  = 0;
    int   n_total = 0;
    int   shadow_m;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Count after k steps, reduced modulo 2^N.
    function automatic int model_shadow(input int sh, input int dir, input int incv, input int k);
        int raw;
        raw = dir ? sh - (incv ? 2 : 1) * k : sh + (incv ? 2 : 1) * k;
        return ((raw % MODV) + MODV) % MODV;
    endfunction

    // Steps move monotonically, so a wrap happened iff the unreduced total left the range.
    function automatic int model_wrap(input int sh, input int dir, input int incv, input int k);
        int raw;
        raw = dir ? sh - (incv ? 2 : 1) * k : sh + (incv ? 2 : 1) * k;
        return (raw < 0 || raw >= MODV) ? 1 : 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 2'b00; abort = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_fields(input int id, input int dir, input int incv, input int reps);
        if (id == 0) begin
            req_dir0 = dir[0]; req_inc0 = incv[0]; req_reps0 = REP_W'(reps);
        end else begin
            req_dir1 = dir[0]; req_inc1 = incv[0]; req_reps1 = REP_W'(reps);
        end
    endtask

    // One burst from a single requester; reports what was observed cycle by cycle.
    task automatic do_burst(input int id, input int dir, input int incv, input int reps, input int ab,
                            output int got, output int steps, output int done_cyc,
                            output int d_id, output int d_wr, output int d_ab, output int bad);
        steps = 0; done_cyc = -1; d_id = -1; d_wr = -1; d_ab = -1; bad = 0; got = 0;
        @(negedge clk);
        set_fields(id, dir, incv, reps);
        req_valid = (id == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < 20 && got == 0; i++) begin
            #1;
            if (req_ready == req_valid) got = 1;
            else @(negedge clk);
        end
        if (got == 0) begin
            req_valid = 2'b00;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            abort = (c == ab);
            #1;
            if (step_en) begin
                steps++;
                if (up_down !== dir[0] || inc !== incv[0]) bad++;
            end
            if (req_ready !== 2'b00 || busy !== 1'b1) bad++;
            if (done) begin
                done_cyc = c; d_id = int'(done_id); d_wr = int'(wrapped); d_ab = int'(aborted);
            end
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int got, steps, dc, did, dwr, dab, bad, exp_steps;
        do_burst(v.id, v.dir, v.inc_v, v.reps, v.ab, got, steps, dc, did, dwr, dab, bad);
        exp_steps = (v.ab != 0) ? v.ab - 1 : v.reps;
        chk({tag, " ready"},    got, 1);
        chk({tag, " steps"},    steps, exp_steps);
        chk({tag, " done_cyc"}, dc, exp_steps + 1 + ((v.ab != 0) ? 1 : 0));
        chk({tag, " done_id"},  did, v.id);
        chk({tag, " wrapped"},  dwr, v.exp_wr);
        chk({tag, " aborted"},  dab, (v.ab != 0) ? 1 : 0);
        chk({tag, " ctrl"},     bad, 0);
        chk({tag, " shadow"},   int'(shadow_count), v.exp_sh);
    endtask

    initial begin
        int cyc, ndone;
        vec_t v;

        reset = 1'b1; req_valid = 2'b00; abort = 1'b0;
        req_dir0 = 1'b0; req_inc0 = 1'b0; req_reps0 = '0;
        req_dir1 = 1'b0; req_inc1 = 1'b0; req_reps1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset step_en", int'(step_en), 0);
        chk("reset busy",    int'(busy), 0);
        chk("reset done",    int'(done), 0);
        chk("reset shadow",  int'(shadow_count), 0);
        chk("reset ready",   int'(req_ready), 0);

        tbl[0] = '{0, 0, 0, 3, 0, 3, 0};
        tbl[1] = '{1, 1, 1, 2, 0, 15, 1};
        tbl[2] = '{0, 0, 0, 0, 0, 15, 0};
        tbl[3] = '{1, 0, 1, 1, 0, 1, 1};
        tbl[4] = '{0, 1, 0, 2, 0, 15, 1};
        tbl[5] = '{1, 0, 1, 7, 0, 13, 1};
        tbl[6] = '{0, 1, 1, 5, 3, 9, 0};
        tbl[7] = '{1, 0, 0, 15, 0, 8, 1};
        for (int i = 0; i < 8; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Abort on the 4th step cycle of a 10-step +2 burst.
        do_reset();
        run_vec("abort", '{0, 0, 1, 10, 4, 6, 0});

        // Reset in the middle of a burst kills it silently.
        @(negedge clk);
        set_fields(0, 0, 0, 8);
        req_valid = 2'b01;
        #1;
        chk("midrst ready", int'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst step_en", int'(step_en), 0);
        chk("midrst shadow",  int'(shadow_count), 0);
        chk("midrst busy",    int'(busy), 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst no done", ndone, 0);

        // Contention: requester 0 first after reset, then requester 1.
        set_fields(0, 0, 0, 1);
        set_fields(1, 0, 0, 1);
        req_valid = 2'b11;
        #1;
        chk("arb first", int'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cyc = -1;
        for (int i = 1; i <= 10 && cyc < 0; i++) begin
            #1;
            if (req_ready != 2'b00) cyc = i;
            else @(negedge clk);
        end
        chk("arb second", int'(req_ready), 2);
        chk("arb gap", cyc, 3);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        cyc = -1;
        for (int i = 1; i <= 10 && cyc < 0; i++) begin
            #1;
            if (done) begin
                cyc = i;
                chk("arb done_id", int'(done_id), 1);
            end
            @(negedge clk);
        end
        chk("arb done_cyc", cyc, 2);
        chk("arb shadow", int'(shadow_count), 2);

        // Random single-requester bursts against the arithmetic model.
        shadow_m = 2;
        for (int i = 0; i < 40; i++) begin
            int k;
            v.id    = int'($urandom_range(1, 0));
            v.dir   = int'($urandom_range(1, 0));
            v.inc_v = int'($urandom_range(1, 0));
            v.reps  = int'($urandom_range(15, 0));
            v.ab    = 0;
            if (v.reps > 0 && $urandom_range(3, 0) == 0) v.ab = int'($urandom_range(v.reps, 1));
            k = (v.ab != 0) ? v.ab - 1 : v.reps;
            v.exp_sh = model_shadow(shadow_m, v.dir, v.inc_v, k);
            v.exp_wr = model_wrap(shadow_m, v.dir, v.inc_v, k);
            run_vec($sformatf("rnd%0d", i), v);
            shadow_m = v.exp_sh;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
